exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Execute-stage controller sitting directly upstream of the ALU.
- Accepts decoded instructions (opcode and operand) from fetch over a valid/ready handshake.
- Registers the operands and drives the ALU enable, opcode and operand inputs for one cycle, then writes the ALU result back into the accumulator and the carry and zero flags.
- Also issues store, jump, return and halt side-effects to the rest of the core.

Parameters:
- SIZE, 8: datapath width of the accumulator, operand and ALU result.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  sequencer can accept an instruction this cycle.
- instr_opcode  in  4  opcode; team encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOT=5 LD=6 ST=7 INC=8 DEC=9 SHL=10 SHR=11 JMP=12 RTN=13 HLT=14 NOP=15.
- instr_operand  in  SIZE  immediate or memory data; jump target for JMP.
- alu_ce  out  1  ALU enable.
- alu_op_code  out  4  opcode to the ALU.
- alu_left  out  SIZE  left operand (always the accumulator).
- alu_right  out  SIZE  right operand (latched instr_operand).
- alu_carry_in  out  1  ALU carry input; constant 0.
- alu_op_out  in  SIZE  ALU result.
- alu_carry_out  in  1  ALU carry result.
- acc  out  SIZE  accumulator.
- carry_flag  out  1  C flag.
- zero_flag  out  1  Z flag.
- st_valid  out  1  one-cycle store strobe.
- st_data  out  SIZE  store data.
- jmp_valid  out  1  one-cycle jump strobe.
- jmp_target  out  SIZE  jump address.
- rtn_valid  out  1  one-cycle return strobe.
- halted  out  1  core halted.

Behaviour:
- Reset (RST=1 at a CLK edge, any state, mid-instruction included):
  - State goes to IDLE.
  - acc, carry_flag, zero_flag, st_data, jmp_target all become 0.
  - All strobes, alu_ce and halted become 0.
  - Any in-flight instruction is discarded and has no effect.
- States and transitions:
  - IDLE: instr_ready=1. On instr_valid=1, latch opcode and operand.
    - Opcodes 0-11 go to EXEC.
    - JMP: pulse jmp_valid with jmp_target=operand on the next cycle; stay in IDLE.
    - RTN: pulse rtn_valid on the next cycle; stay in IDLE.
    - NOP: no effect; stay in IDLE.
    - HLT: go to HALT.
  - EXEC: instr_ready=0, alu_ce=1, alu_op_code=latched opcode, alu_left=acc, alu_right=latched operand. Go to WB.
  - WB: instr_ready=0, alu_ce=0. Sample alu_op_out and alu_carry_out as they were at the end of EXEC (results are captured at the EXEC→WB edge). Commit per the write-back rules below. Go to IDLE.
  - HALT: halted=1, instr_ready=0; instr_valid is ignored. Exit only via RST.
- Throughput and ALU-drive rules:
  - ALU opcodes take 3 cycles: accept, EXEC, WB. The next accept is possible in the cycle after WB.
  - Control opcodes take 1 cycle and allow back-to-back acceptance.
  - Outside EXEC, alu_ce=0 and alu_op_code/alu_left/alu_right hold their previous values; the ALU must not see spurious toggles.
- Write-back rules:
  - ADD, SUB: acc ← op_out; C ← carry_out; Z ← (op_out==0).
  - AND, OR, XOR, NOT, LD, INC, DEC, SHL, SHR: acc ← op_out; Z ← (op_out==0); C unchanged.
  - INC/DEC wrap modulo 2^SIZE (0xFF+1→0x00, Z=1; 0x00−1→0xFF).
  - ST: acc, C and Z unchanged; st_valid=1 for exactly one cycle (the cycle after WB) with st_data=op_out.
  - Z is computed locally from alu_op_out; the ALU zero output is not used.
- Handshake: a transfer occurs only when instr_valid and instr_ready are both 1 at a CLK edge. instr_opcode/instr_operand are don't-care otherwise.
- Simultaneous events: RST takes priority over instr_valid, write-back and HLT in the same cycle.

Test Plan:
- Reset, then LD 0x3C → after WB: acc=0x3C, Z=0, C=0, alu_ce high exactly one cycle, instr_ready low for 2 cycles.
- LD 0xF0, ADD 0x20 → acc=0x10, C=1, Z=0; then SUB 0x10 → acc=0x00, Z=1, C from ALU carry_out.
- LD 0xFF, INC → acc=0x00, Z=1, C unchanged; DEC → acc=0xFF, Z=0.
- LD 0xA5, ST → st_valid one-cycle pulse with st_data=0xA5, acc=0xA5; then JMP 0x42 and RTN back-to-back → jmp_valid with target 0x42, then rtn_valid, instr_ready held at 1 throughout.
- HLT, then instr_valid=1 with ADD for 10 cycles → halted=1, instr_ready=0, acc unchanged; RST → halted=0, acc=0, IDLE.
- Assert RST during EXEC of ADD 0x01 → acc stays 0, no write-back, alu_ce=0 on the following cycle.

Source files
------------

// File: rtl/exec_sequencer.sv
// Execute-stage controller: hands decoded instructions to the ALU, commits results
// to the accumulator/flags and issues store, jump, return and halt side-effects.
module exec_sequencer #(
  parameter int unsigned SIZE = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [3:0]      instr_opcode,
  input  logic [SIZE-1:0] instr_operand,
  output logic            alu_ce,
  output logic [3:0]      alu_op_code,
  output logic [SIZE-1:0] alu_left,
  output logic [SIZE-1:0] alu_right,
  output logic            alu_carry_in,
  input  logic [SIZE-1:0] alu_op_out,
  input  logic            alu_carry_out,
  output logic [SIZE-1:0] acc,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic            st_valid,
  output logic [SIZE-1:0] st_data,
  output logic            jmp_valid,
  output logic [SIZE-1:0] jmp_target,
  output logic            rtn_valid,
  output logic            halted
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ST  = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12;
  localparam logic [3:0] OP_RTN = 4'd13;
  localparam logic [3:0] OP_HLT = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_t;

  state_t          state;
  logic [SIZE-1:0] res_q;
  logic            res_c_q;

  assign alu_carry_in = 1'b0;

  // ALU drive registers only change on acceptance, so the ALU inputs stay quiet otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      alu_ce      <= 1'b0;
      alu_op_code <= 4'd0;
      alu_left    <= '0;
      alu_right   <= '0;
      res_q       <= '0;
      res_c_q     <= 1'b0;
      acc         <= '0;
      carry_flag  <= 1'b0;
      zero_flag   <= 1'b0;
      st_valid    <= 1'b0;
      st_data     <= '0;
      jmp_valid   <= 1'b0;
      jmp_target  <= '0;
      rtn_valid   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      st_valid  <= 1'b0;
      jmp_valid <= 1'b0;
      rtn_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            if (instr_opcode <= OP_SHR) begin
              state       <= S_EXEC;
              instr_ready <= 1'b0;
              alu_ce      <= 1'b1;
              alu_op_code <= instr_opcode;
              alu_left    <= acc;
              alu_right   <= instr_operand;
            end else begin
              case (instr_opcode)
                OP_JMP: begin
                  jmp_valid  <= 1'b1;
                  jmp_target <= instr_operand;
                end
                OP_RTN: rtn_valid <= 1'b1;
                OP_HLT: begin
                  state       <= S_HALT;
                  instr_ready <= 1'b0;
                  halted      <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        S_EXEC: begin
          alu_ce  <= 1'b0;
          res_q   <= alu_op_out;
          res_c_q <= alu_carry_out;
          state   <= S_WB;
        end
        S_WB: begin
          case (alu_op_code)
            OP_ADD, OP_SUB: begin
              acc        <= res_q;
              carry_flag <= res_c_q;
              zero_flag  <= (res_q == '0);
            end
            OP_ST: begin
              st_valid <= 1'b1;
              st_data  <= res_q;
            end
            default: begin
              acc       <= res_q;
              zero_flag <= (res_q == '0);
            end
          endcase
          state       <= S_IDLE;
          instr_ready <= 1'b1;
        end
        default: begin
          state       <= S_HALT;
          instr_ready <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer with a behavioural ALU in the loop.
module tb_exec_sequencer;
  localparam int unsigned SIZE = 8;

  logic            CLK, RST;
  logic            instr_valid, instr_ready;
  logic [3:0]      instr_opcode;
  logic [SIZE-1:0] instr_operand;
  logic            alu_ce;
  logic [3:0]      alu_op_code;
  logic [SIZE-1:0] alu_left, alu_right;
  logic            alu_carry_in;
  logic [SIZE-1:0] alu_op_out;
  logic            alu_carry_out;
  logic [SIZE-1:0] acc;
  logic            carry_flag, zero_flag;
  logic            st_valid;
  logic [SIZE-1:0] st_data;
  logic            jmp_valid;
  logic [SIZE-1:0] jmp_target;
  logic            rtn_valid, halted;

  exec_sequencer #(.SIZE(SIZE)) dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .alu_ce(alu_ce), .alu_op_code(alu_op_code), .alu_left(alu_left),
    .alu_right(alu_right), .alu_carry_in(alu_carry_in),
    .alu_op_out(alu_op_out), .alu_carry_out(alu_carry_out),
    .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .st_valid(st_valid), .st_data(st_data),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .rtn_valid(rtn_valid), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU; non-arithmetic ops drive carry high so a stray C update shows up.
  always_comb begin
    alu_op_out    = '0;
    alu_carry_out = 1'b1;
    case (alu_op_code)
      4'd0:  {alu_carry_out, alu_op_out} = {1'b0, alu_left} + {1'b0, alu_right};
      4'd1:  {alu_carry_out, alu_op_out} = {1'b0, alu_left} - {1'b0, alu_right};
      4'd2:  alu_op_out = alu_left & alu_right;
      4'd3:  alu_op_out = alu_left | alu_right;
      4'd4:  alu_op_out = alu_left ^ alu_right;
      4'd5:  alu_op_out = ~alu_left;
      4'd6:  alu_op_out = alu_right;
      4'd7:  alu_op_out = alu_left;
      4'd8:  alu_op_out = alu_left + 8'd1;
      4'd9:  alu_op_out = alu_left - 8'd1;
      4'd10: alu_op_out = alu_left << 1;
      4'd11: alu_op_out = alu_left >> 1;
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0]      op;
    logic [SIZE-1:0] left;
    logic [SIZE-1:0] right;
  } alu_exp_t;

  typedef struct {
    logic [SIZE-1:0] acc;
    logic            c;
    logic            z;
  } wb_exp_t;

  alu_exp_t        alu_q[$];
  wb_exp_t         wb_q[$];
  logic [SIZE-1:0] st_q[$];
  logic [SIZE-1:0] jmp_q[$];
  int              rtn_pending = 0;

  int errors = 0;
  int checks = 0;
  int wb_pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents ALU drive, write-back or a strobe.
  always @(negedge CLK) begin
    if (RST) begin
      wb_pending = 0;
    end else begin
      if (wb_pending == 1) begin
        if (wb_q.size() == 0) chk("wb_queue_underflow", 1, 0);
        else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          chk("wb_acc", 32'(acc), 32'(w.acc));
          chk("wb_carry", 32'(carry_flag), 32'(w.c));
          chk("wb_zero", 32'(zero_flag), 32'(w.z));
        end
      end
      if (wb_pending > 0) wb_pending--;
      if (alu_ce) begin
        if (alu_q.size() == 0) chk("alu_ce_unexpected", 1, 0);
        else begin
          alu_exp_t a;
          a = alu_q.pop_front();
          chk("alu_op_code", 32'(alu_op_code), 32'(a.op));
          chk("alu_left", 32'(alu_left), 32'(a.left));
          chk("alu_right", 32'(alu_right), 32'(a.right));
          wb_pending = 2;
        end
      end
      if (st_valid) begin
        if (st_q.size() == 0) chk("st_valid_unexpected", 1, 0);
        else chk("st_data", 32'(st_data), 32'(st_q.pop_front()));
      end
      if (jmp_valid) begin
        if (jmp_q.size() == 0) chk("jmp_valid_unexpected", 1, 0);
        else chk("jmp_target", 32'(jmp_target), 32'(jmp_q.pop_front()));
      end
      if (rtn_valid) begin
        chk("rtn_valid_expected", 32'(rtn_pending > 0), 1);
        if (rtn_pending > 0) rtn_pending--;
      end
    end
  end

  // Presents one instruction and returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [SIZE-1:0] opd);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    instr_valid   = 1'b1;
    instr_opcode  = op;
    instr_operand = opd;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
  endtask

  task automatic run_alu(input logic [3:0] op, input logic [SIZE-1:0] opd,
                         input logic [SIZE-1:0] left, input logic [SIZE-1:0] e_acc,
                         input logic e_c, input logic e_z);
    alu_q.push_back('{op: op, left: left, right: opd});
    wb_q.push_back('{acc: e_acc, c: e_c, z: e_z});
    if (op == 4'd7) st_q.push_back(e_acc);
    send(op, opd);
  endtask

  initial begin
    RST = 1'b1;
    instr_valid = 1'b0;
    instr_opcode = 4'd15;
    instr_operand = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_acc", 32'(acc), 0);
    chk("rst_flags", 32'({carry_flag, zero_flag}), 0);
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_alu_ce", 32'(alu_ce), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_strobes", 32'({st_valid, jmp_valid, rtn_valid}), 0);
    chk("rst_carry_in", 32'(alu_carry_in), 0);
    RST = 1'b0;

    // First load also checks the 3-cycle occupancy pattern.
    run_alu(4'd6, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0);
    chk("ld_exec_alu_ce", 32'(alu_ce), 1);
    chk("ld_exec_ready", 32'(instr_ready), 0);
    @(posedge CLK); #1;
    chk("ld_wb_alu_ce", 32'(alu_ce), 0);
    chk("ld_wb_ready", 32'(instr_ready), 0);
    @(posedge CLK); #1;
    chk("ld_idle_ready", 32'(instr_ready), 1);

    //      op     opd    left   acc    C     Z
    run_alu(4'd6,  8'hF0, 8'h3C, 8'hF0, 1'b0, 1'b0);
    run_alu(4'd0,  8'h20, 8'hF0, 8'h10, 1'b1, 1'b0);
    run_alu(4'd6,  8'hFF, 8'h10, 8'hFF, 1'b1, 1'b0);
    run_alu(4'd8,  8'h00, 8'hFF, 8'h00, 1'b1, 1'b1);
    run_alu(4'd9,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0);
    run_alu(4'd6,  8'h10, 8'hFF, 8'h10, 1'b1, 1'b0);
    run_alu(4'd1,  8'h10, 8'h10, 8'h00, 1'b0, 1'b1);
    run_alu(4'd6,  8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);
    run_alu(4'd7,  8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0);
    run_alu(4'd4,  8'hFF, 8'hA5, 8'h5A, 1'b0, 1'b0);
    run_alu(4'd10, 8'h00, 8'h5A, 8'hB4, 1'b0, 1'b0);
    run_alu(4'd11, 8'h00, 8'hB4, 8'h5A, 1'b0, 1'b0);
    run_alu(4'd2,  8'h0F, 8'h5A, 8'h0A, 1'b0, 1'b0);
    run_alu(4'd3,  8'hF0, 8'h0A, 8'hFA, 1'b0, 1'b0);
    run_alu(4'd2,  8'h00, 8'hFA, 8'h00, 1'b0, 1'b1);
    run_alu(4'd5,  8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);

    // Control opcodes back to back.
    jmp_q.push_back(8'h42);
    send(4'd12, 8'h42);
    chk("jmp_ready", 32'(instr_ready), 1);
    rtn_pending++;
    send(4'd13, 8'h00);
    chk("rtn_ready", 32'(instr_ready), 1);
    send(4'd15, 8'h77);
    chk("nop_ready", 32'(instr_ready), 1);
    chk("nop_acc", 32'(acc), 32'(8'hFF));

    // Halt ignores further traffic.
    send(4'd14, 8'h00);
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_ready", 32'(instr_ready), 0);
    instr_valid   = 1'b1;
    instr_opcode  = 4'd0;
    instr_operand = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("halt_hold_halted", 32'(halted), 1);
      chk("halt_hold_ready", 32'(instr_ready), 0);
      chk("halt_hold_acc", 32'(acc), 32'(8'hFF));
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    chk("unhalt_halted", 32'(halted), 0);
    chk("unhalt_acc", 32'(acc), 0);
    chk("unhalt_ready", 32'(instr_ready), 1);
    RST = 1'b0;

    // Reset lands in EXEC: no write-back may follow.
    send(4'd0, 8'h01);
    chk("abort_exec_alu_ce", 32'(alu_ce), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_alu_ce", 32'(alu_ce), 0);
    chk("abort_ready", 32'(instr_ready), 1);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_acc", 32'(acc), 0);
    chk("abort_flags", 32'({carry_flag, zero_flag}), 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("alu_q_drained", 32'(alu_q.size()), 0);
    chk("wb_q_drained", 32'(wb_q.size()), 0);
    chk("st_q_drained", 32'(st_q.size()), 0);
    chk("jmp_q_drained", 32'(jmp_q.size()), 0);
    chk("rtn_drained", 32'(rtn_pending), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
